mem_stage: RTL and testbench

Memory-access stage of the five-stage ARM pipeline, directly downstream of the execute stage. It registers the execute-stage results into the M-stage pipeline register and runs a request/acknowledge transaction on the data-memory bus for loads and stores. While an access is outstanding it stalls the pipeline. It presents M-stage values to the writeback stage and to the forwarding and hazard logic.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_stage_mreg.sv | 37 +++
 rtl/mem_stage.sv | 95 +++++++++
 tb/tb_mem_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the M (memory-access) pipeline stage.
// Holds the bus FSM state encoding and the M-stage control bundle.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemWrite;
  } mctrl_t;

endpackage

// File: rtl/mem_stage_mreg.sv
// M pipeline register: captures execute-stage results unless stalled.
// A flush (honoured only when not stalled) loads an all-zero control bubble.
module mreg
  import mem_stage_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  mctrl_t        ctrlE,
  input  logic [3:0]    rdE,
  input  logic [DW-1:0] aluResultE,
  input  logic [DW-1:0] writeDataE,
  output mctrl_t        ctrlM,
  output logic [3:0]    rdM,
  output logic [DW-1:0] aluResultM,
  output logic [DW-1:0] writeDataM
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrlM      <= '0;
      rdM        <= '0;
      aluResultM <= '0;
      writeDataM <= '0;
    end else if (!stall) begin
      // Data fields are don't-care under flush, so they load unconditionally.
      ctrlM      <= flush ? '0 : ctrlE;
      rdM        <= rdE;
      aluResultM <= aluResultE;
      writeDataM <= writeDataE;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: M pipeline register plus a req/ack data-memory bus FSM.
// Stalls the pipeline while a load or store is outstanding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          RegWriteE,
  input  logic          MemtoRegE,
  input  logic          MemWriteE,
  input  logic [3:0]    RdE,
  input  logic [DW-1:0] ALUResultE,
  input  logic [DW-1:0] WriteDataE,
  output logic          RegWriteM,
  output logic          MemtoRegM,
  output logic [3:0]    RdM,
  output logic [DW-1:0] ALUResultM,
  output logic [DW-1:0] ReadDataM,
  output logic          stallM,
  output logic          misalignM,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack
);

  mctrl_t        ctrlE;
  mctrl_t        ctrlM;
  logic [DW-1:0] writeDataM;
  mem_state_t    state;
  logic          memAccess;
  logic          memop;
  logic          ackTaken;

  assign ctrlE = '{RegWrite: RegWriteE, MemtoReg: MemtoRegE, MemWrite: MemWriteE};

  mreg #(.DW(DW)) uMreg (
    .clk        (clk),
    .reset      (reset),
    .stall      (stallM),
    .flush      (flush),
    .ctrlE      (ctrlE),
    .rdE        (RdE),
    .aluResultE (ALUResultE),
    .writeDataE (WriteDataE),
    .ctrlM      (ctrlM),
    .rdM        (RdM),
    .aluResultM (ALUResultM),
    .writeDataM (writeDataM)
  );

  // Misaligned accesses never reach the bus and never write the register file.
  assign memAccess = ctrlM.MemtoReg | ctrlM.MemWrite;
  assign misalignM = memAccess & (ALUResultM[1:0] != 2'b00);
  assign memop     = memAccess & ~misalignM;
  assign RegWriteM = ctrlM.RegWrite & ~misalignM;
  assign MemtoRegM = ctrlM.MemtoReg;

  // Request is live in IDLE (first cycle) and BUSY; DONE releases the stall.
  assign stallM     = memop & (state != DONE);
  assign dmem_req   = stallM;
  assign dmem_we    = ctrlM.MemWrite;
  assign dmem_addr  = AW'(ALUResultM);
  assign dmem_wdata = writeDataM;
  assign ackTaken   = dmem_req & dmem_ack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (memop) state <= dmem_ack ? DONE : BUSY;
        BUSY:    if (dmem_ack) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Load data is captured only for an acknowledged load; stray acks are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ReadDataM <= '0;
    end else if (ackTaken && !dmem_we) begin
      ReadDataM <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: scoreboard of expected M-stage results,
// with the bench acting as a data-memory responder with programmable ack delay.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        RegWriteE = 1'b0, MemtoRegE = 1'b0, MemWriteE = 1'b0;
  logic [3:0]  RdE = 4'd0;
  logic [31:0] ALUResultE = 32'd0, WriteDataE = 32'd0;
  logic        RegWriteM, MemtoRegM;
  logic [3:0]  RdM;
  logic [31:0] ALUResultM, ReadDataM;
  logic        stallM, misalignM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [3:0]  rd;
    logic [31:0] alu;
    logic        mis;
    logic        memop;
    logic        we;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] readExp;
  } exp_t;

  exp_t        sb[$];
  int          nChecks = 0;
  int          nErrors = 0;
  logic [31:0] lastRead = 32'd0;

  mem_stage #(.AW(32), .DW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .RegWriteE  (RegWriteE),
    .MemtoRegE  (MemtoRegE),
    .MemWriteE  (MemWriteE),
    .RdE        (RdE),
    .ALUResultE (ALUResultE),
    .WriteDataE (WriteDataE),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .ReadDataM  (ReadDataM),
    .stallM     (stallM),
    .misalignM  (misalignM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setE(input logic rw, input logic m2r, input logic mw, input logic [3:0] rd,
                      input logic [31:0] alu, input logic [31:0] wd);
    RegWriteE  = rw;
    MemtoRegE  = m2r;
    MemWriteE  = mw;
    RdE        = rd;
    ALUResultE = alu;
    WriteDataE = wd;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, ".RegWriteM"}, 32'(RegWriteM), 32'd0);
    checkVal({tag, ".MemtoRegM"}, 32'(MemtoRegM), 32'd0);
    checkVal({tag, ".RdM"}, 32'(RdM), 32'd0);
    checkVal({tag, ".ALUResultM"}, ALUResultM, 32'd0);
    checkVal({tag, ".ReadDataM"}, ReadDataM, 32'd0);
    checkVal({tag, ".stallM"}, 32'(stallM), 32'd0);
    checkVal({tag, ".misalignM"}, 32'(misalignM), 32'd0);
    checkVal({tag, ".dmem_req"}, 32'(dmem_req), 32'd0);
  endtask

  // Issue one instruction from E; entered and left on a negedge with stallM low.
  task automatic doOp(input string tag, input logic rw, input logic m2r, input logic mw,
                      input logic [3:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                      input int ackWait, input logic [31:0] rdata, input bit flushMid);
    exp_t e;
    int   cnt;
    e.rw    = rw;
    e.m2r   = m2r;
    e.rd    = rd;
    e.alu   = alu;
    e.we    = mw;
    e.wdata = wd;
    e.mis   = (m2r | mw) && (alu[1:0] != 2'b00);
    e.memop = (m2r | mw) && !e.mis;
    if (e.mis) e.rw = 1'b0;
    e.stalls = e.memop ? ackWait + 1 : 0;
    if (e.memop && !mw) lastRead = rdata;
    e.readExp = lastRead;
    sb.push_back(e);

    setE(rw, m2r, mw, rd, alu, wd);
    tick();
    setE(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    e = sb.pop_front();
    checkVal({tag, ".RegWriteM"}, 32'(RegWriteM), 32'(e.rw));
    checkVal({tag, ".MemtoRegM"}, 32'(MemtoRegM), 32'(e.m2r));
    checkVal({tag, ".RdM"}, 32'(RdM), 32'(e.rd));
    checkVal({tag, ".ALUResultM"}, ALUResultM, e.alu);
    checkVal({tag, ".misalignM"}, 32'(misalignM), 32'(e.mis));

    cnt = 0;
    while (stallM && cnt < 40) begin
      checkVal({tag, ".req"}, 32'(dmem_req), 32'd1);
      checkVal({tag, ".we"}, 32'(dmem_we), 32'(e.we));
      checkVal({tag, ".addr"}, dmem_addr, e.alu);
      if (e.we) checkVal({tag, ".wdata"}, dmem_wdata, e.wdata);
      dmem_ack   = (cnt == ackWait);
      dmem_rdata = (cnt == ackWait) ? rdata : ~rdata;
      flush      = flushMid && (cnt == 1);
      tick();
      dmem_ack = 1'b0;
      flush    = 1'b0;
      cnt++;
      checkVal({tag, ".heldRd"}, 32'(RdM), 32'(e.rd));
      checkVal({tag, ".heldCtl"}, 32'(MemtoRegM), 32'(e.m2r));
    end
    checkVal({tag, ".stallCycles"}, 32'(cnt), 32'(e.stalls));
    checkVal({tag, ".reqAfter"}, 32'(dmem_req), 32'd0);
    checkVal({tag, ".ReadDataM"}, ReadDataM, e.readExp);
  endtask

  initial begin
    int          kind;
    logic [31:0] r;
    logic [31:0] addr;

    // Reset state
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkZero("reset");
    reset = 1'b1;

    doOp("alu", 1'b1, 1'b0, 1'b0, 4'd3, 32'h1234, 32'd0, 0, 32'd0, 1'b0);
    doOp("ld0", 1'b1, 1'b1, 1'b0, 4'd7, 32'h100, 32'd0, 0, 32'hDEADBEEF, 1'b0);
    doOp("st3", 1'b0, 1'b0, 1'b1, 4'd0, 32'h200, 32'hCAFEF00D, 3, 32'h13572468, 1'b0);
    doOp("ldMis", 1'b1, 1'b1, 1'b0, 4'd9, 32'h102, 32'd0, 0, 32'h55555555, 1'b0);
    doOp("stMis", 1'b0, 1'b0, 1'b1, 4'd2, 32'h203, 32'h1111, 0, 32'd0, 1'b0);
    doOp("ldFlushBusy", 1'b1, 1'b1, 1'b0, 4'd4, 32'h300, 32'd0, 3, 32'h0BADF00D, 1'b1);

    // Flush in DONE is honoured: M receives a zero-control bubble
    setE(1'b1, 1'b1, 1'b0, 4'd6, 32'h400, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    setE(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    checkVal("bubble.RegWriteM", 32'(RegWriteM), 32'd0);
    checkVal("bubble.MemtoRegM", 32'(MemtoRegM), 32'd0);
    checkVal("bubble.stallM", 32'(stallM), 32'd0);
    checkVal("bubble.req", 32'(dmem_req), 32'd0);

    // Back-to-back mix with random delays
    for (int i = 0; i < 8; i++) begin
      kind = int'($urandom_range(0, 2));
      r    = $urandom;
      addr = {r[31:2], 2'b00};
      doOp("mix", kind != 2, kind == 1, kind == 2, 4'($urandom_range(0, 15)), addr,
           $urandom, int'($urandom_range(0, 3)), $urandom, 1'b0);
    end

    // Reset while a load is in BUSY, then a late ack that must be ignored
    setE(1'b1, 1'b1, 1'b0, 4'd8, 32'h500, 32'd0);
    tick();
    setE(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    tick();
    checkVal("rstBusy.req", 32'(dmem_req), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    lastRead = 32'd0;
    checkZero("rstMid");
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF0000;
    tick();
    dmem_ack = 1'b0;
    checkVal("lateAck.ReadDataM", ReadDataM, 32'd0);
    checkVal("lateAck.stallM", 32'(stallM), 32'd0);
    checkVal("lateAck.req", 32'(dmem_req), 32'd0);
    doOp("ldPostRst", 1'b1, 1'b1, 1'b0, 4'd1, 32'h600, 32'd0, 1, 32'hA5A5A5A5, 1'b0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
